// File: rtl/tsp_2opt_sched.sv
// tsp_2opt_sched: 2-opt move scheduler for the TSP engine.
// It walks every legal (i, j) edge pair through the shared gain evaluator.
// When a pair reports a positive gain, it asks the reversal unit to reverse path[i+1..j].
// Full sweeps repeat until a sweep makes no improvement, or until the optional sweep cap is hit.
// Optional feature macro: TSP_SCHED_RESTART_EN. When it is defined, every completed reversal
// restarts the sweep at (0, 2).
module tsp_2opt_sched #(
    parameter int N          = 64,
    parameter int IDX_W      = 6,
    parameter int GAIN_W     = 12,
    parameter int MAX_SWEEPS = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [IDX_W-1:0]         ev_i,
    output logic [IDX_W-1:0]         ev_j,
    input  logic                     res_valid,
    input  logic signed [GAIN_W-1:0] res_gain,
    output logic                     rev_valid,
    input  logic                     rev_ready,
    output logic [IDX_W-1:0]         rev_lo,
    output logic [IDX_W-1:0]         rev_hi,
    input  logic                     rev_done,
    output logic [15:0]              sweep_cnt,
    output logic [15:0]              improve_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_RES = 3'd2;
    localparam logic [2:0] S_REVERSE  = 3'd3;
    localparam logic [2:0] S_WAIT_REV = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [IDX_W-1:0] IDX_ZERO   = '0;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TWO    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_THREE  = IDX_W'(3);
    localparam logic [IDX_W-1:0] LAST_I     = IDX_W'(N - 3);
    localparam logic [IDX_W-1:0] LAST_J     = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] SKIP_J     = IDX_W'(N - 2);
    localparam logic             CAP_EN     = (MAX_SWEEPS != 0);
    localparam logic [15:0]      CAP_SWEEPS = 16'(MAX_SWEEPS);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic             imp_q, imp_d;
    logic [15:0]      sweep_q, sweep_d, improve_q, improve_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             ev_valid_q, ev_valid_d, rev_valid_q, rev_valid_d;
    logic [IDX_W-1:0] ev_i_q, ev_i_d, ev_j_q, ev_j_d;
    logic [IDX_W-1:0] rev_lo_q, rev_lo_d, rev_hi_q, rev_hi_d;

    logic [IDX_W-1:0] adv_i, adv_j;
    logic             sweep_end;
    logic             do_adv;
    logic             gain_pos;

    // A gain is positive when the sign bit is clear and the value is nonzero.
    assign gain_pos = !res_gain[GAIN_W-1] && (res_gain != '0);

    // Successor of the current pair. The (0, N-1) pair is skipped because its two edges are adjacent.
    always_comb begin
        adv_i     = i_q;
        adv_j     = j_q;
        sweep_end = 1'b0;
        if (i_q == LAST_I && j_q == LAST_J) begin
            sweep_end = 1'b1;
        end else if (i_q == IDX_ZERO && j_q == SKIP_J) begin
            adv_i = IDX_ONE;
            adv_j = IDX_THREE;
        end else if (j_q != LAST_J) begin
            adv_j = j_q + IDX_ONE;
        end else begin
            adv_i = i_q + IDX_ONE;
            adv_j = i_q + IDX_THREE;
        end
    end

    // Next-state logic for the FSM, the pair register, the counters, and the registered outputs.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        imp_d     = imp_q;
        sweep_d   = sweep_q;
        improve_d = improve_q;
        do_adv    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sweep_d   = '0;
                    improve_d = '0;
                    imp_d     = 1'b0;
                    i_d       = IDX_ZERO;
                    j_d       = IDX_TWO;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ev_valid_q && ev_ready) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    if (gain_pos) begin
                        state_d = S_REVERSE;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            S_REVERSE: begin
                if (rev_valid_q && rev_ready) begin
                    state_d   = S_WAIT_REV;
                    imp_d     = 1'b1;
                    improve_d = (improve_q == 16'hFFFF) ? improve_q : improve_q + 16'd1;
                end
            end
            S_WAIT_REV: begin
                if (rev_done) begin
`ifdef TSP_SCHED_RESTART_EN
                    // After a reversal the sweep starts over, so a sweep only ends with no reversal in it.
                    i_d     = IDX_ZERO;
                    j_d     = IDX_TWO;
                    imp_d   = 1'b0;
                    state_d = S_ISSUE;
`else
                    do_adv = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_adv) begin
            if (sweep_end) begin
                sweep_d = (sweep_q == 16'hFFFF) ? sweep_q : sweep_q + 16'd1;
                if (!imp_q || (CAP_EN && sweep_d >= CAP_SWEEPS)) begin
                    state_d = S_DONE;
                end else begin
                    imp_d   = 1'b0;
                    i_d     = IDX_ZERO;
                    j_d     = IDX_TWO;
                    state_d = S_ISSUE;
                end
            end else begin
                i_d     = adv_i;
                j_d     = adv_j;
                state_d = S_ISSUE;
            end
        end

        // Outputs are decoded from the next state, so each output is a flop.
        ev_valid_d  = (state_d == S_ISSUE);
        ev_i_d      = ev_valid_d ? i_d : IDX_ZERO;
        ev_j_d      = ev_valid_d ? j_d : IDX_ZERO;
        rev_valid_d = (state_d == S_REVERSE);
        rev_lo_d    = rev_valid_d ? (i_d + IDX_ONE) : IDX_ZERO;
        rev_hi_d    = rev_valid_d ? j_d : IDX_ZERO;
        busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT_RES) ||
                      (state_d == S_REVERSE) || (state_d == S_WAIT_REV);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers. rst_n is an asynchronous reset that abandons any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            i_q         <= IDX_ZERO;
            j_q         <= IDX_TWO;
            imp_q       <= 1'b0;
            sweep_q     <= '0;
            improve_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_i_q      <= '0;
            ev_j_q      <= '0;
            rev_valid_q <= 1'b0;
            rev_lo_q    <= '0;
            rev_hi_q    <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            imp_q       <= imp_d;
            sweep_q     <= sweep_d;
            improve_q   <= improve_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ev_valid_q  <= ev_valid_d;
            ev_i_q      <= ev_i_d;
            ev_j_q      <= ev_j_d;
            rev_valid_q <= rev_valid_d;
            rev_lo_q    <= rev_lo_d;
            rev_hi_q    <= rev_hi_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ev_valid    = ev_valid_q;
    assign ev_i        = ev_i_q;
    assign ev_j        = ev_j_q;
    assign rev_valid   = rev_valid_q;
    assign rev_lo      = rev_lo_q;
    assign rev_hi      = rev_hi_q;
    assign sweep_cnt   = sweep_q;
    assign improve_cnt = improve_q;

endmodule

// File: tb/tb_tsp_2opt_sched.sv
// tb_tsp_2opt_sched: scoreboard bench for the 2-opt scheduler (N=64, MAX_SWEEPS=2).
// The main process pushes the expected sequence of evaluation and reversal requests into a queue.
// A monitor compares each request the DUT presents against the head of that queue.
// A responder plays the roles of the evaluator and the reversal unit.
module tb_tsp_2opt_sched;

    localparam int NC = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, ev_valid, rev_valid;
    logic              ev_ready = 1'b1;
    logic              rev_ready = 1'b1;
    logic [5:0]        ev_i, ev_j, rev_lo, rev_hi;
    logic              res_valid = 1'b0;
    logic signed [11:0] res_gain = '0;
    logic              rev_done = 1'b0;
    logic [15:0]       sweep_cnt, improve_cnt;

    tsp_2opt_sched #(.N(64), .IDX_W(6), .GAIN_W(12), .MAX_SWEEPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_i(ev_i), .ev_j(ev_j),
        .res_valid(res_valid), .res_gain(res_gain),
        .rev_valid(rev_valid), .rev_ready(rev_ready), .rev_lo(rev_lo), .rev_hi(rev_hi),
        .rev_done(rev_done), .sweep_cnt(sweep_cnt), .improve_cnt(improve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kind;   // 0 = evaluation request (i, j), 1 = reversal request (lo, hi)
        int a;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mode = 1;
    int   tb_sweep = 0;
    int   ev_hold = 0;
    int   rev_hold = 0;
    bit   hold_rev_done = 1'b0;
    int   ev_count = 0;
    int   exp_evs = 0;
    int   last_i = -1;
    int   last_j = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Pushes one sweep of expected requests. When stop_at_rev is set, the push ends after the first reversal.
    task automatic push_sweep(input int ri, input int rj, input bit rev_all, input bit stop_at_rev);
        exp_t e;
        for (int i = 0; i <= NC - 3; i++) begin
            for (int j = i + 2; j <= NC - 1; j++) begin
                if (i == 0 && j == NC - 1) continue;
                e.kind = 1'b0; e.a = i; e.b = j;
                exp_q.push_back(e);
                exp_evs++;
                if (rev_all || (i == ri && j == rj)) begin
                    e.kind = 1'b1; e.a = i + 1; e.b = j;
                    exp_q.push_back(e);
                    if (stop_at_rev) return;
                end
            end
        end
    endtask

    function automatic logic signed [11:0] gain_for(input int m, input int sw, input int i, input int j);
        case (m)
            2: return (sw == 1 && i == 3 && j == 10) ? 12'sd5 : -12'sd1;
            4: begin
                if (i == 5 && j == 20) return -12'sd1020;
                if (sw == 1 && i == 7 && j == 30) return 12'sd1;
                return 12'sd0;
            end
            5: return 12'sd1;
            default: return 12'sd0;
        endcase
    endfunction

    // Evaluator and reversal unit model: it answers one cycle after each handshake and applies optional ready stalls.
    initial begin
        bit pend_ev, pend_rev;
        int cap_i, cap_j;
        forever begin
            @(negedge clk);
            pend_ev  = rst_n && ev_valid && ev_ready;
            pend_rev = rst_n && rev_valid && rev_ready;
            cap_i    = int'(ev_i);
            cap_j    = int'(ev_j);
            if (pend_ev && cap_i == 0 && cap_j == 2) tb_sweep++;
            @(posedge clk);
            #1;
            res_valid = pend_ev;
            res_gain  = pend_ev ? gain_for(mode, tb_sweep, cap_i, cap_j) : 12'sd0;
            rev_done  = pend_rev && !hold_rev_done;
            if (ev_valid && ev_hold > 0) begin
                ev_ready = 1'b0;
                ev_hold--;
            end else begin
                ev_ready = 1'b1;
            end
            if (rev_valid && rev_hold > 0) begin
                rev_ready = 1'b0;
                rev_hold--;
            end else begin
                rev_ready = 1'b1;
            end
        end
    end

    // Monitor: on every cycle a request is valid, compare it with the queue head. Pop only on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ev_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL ev_pair: got unexpected ev (%0d,%0d), expected no request", ev_i, ev_j);
                end else if (exp_q[0].kind != 1'b0 || int'(ev_i) != exp_q[0].a ||
                             int'(ev_j) != exp_q[0].b || rev_valid) begin
                    fails++;
                    $display("FAIL ev_pair: got ev (%0d,%0d) rev_valid=%b, expected kind=%0d (%0d,%0d)",
                             ev_i, ev_j, rev_valid, exp_q[0].kind, exp_q[0].a, exp_q[0].b);
                end
                if (ev_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    ev_count++;
                    last_i = int'(ev_i);
                    last_j = int'(ev_j);
                end
            end
            if (rst_n && rev_valid && !ev_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rev_range: got unexpected rev (%0d,%0d), expected no request", rev_lo, rev_hi);
                end else if (exp_q[0].kind != 1'b1 || int'(rev_lo) != exp_q[0].a ||
                             int'(rev_hi) != exp_q[0].b) begin
                    fails++;
                    $display("FAIL rev_range: got rev (%0d,%0d), expected kind=%0d (%0d,%0d)",
                             rev_lo, rev_hi, exp_q[0].kind, exp_q[0].a, exp_q[0].b);
                end
                if (rev_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic recover();
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        ev_hold = 0; rev_hold = 0; hold_rev_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic prep(input int m);
        exp_q.delete();
        mode = m; tb_sweep = 0; ev_count = 0; exp_evs = 0;
        last_i = -1; last_j = -1;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, n);
            recover();
        end
    endtask

    task automatic end_checks(input string name, input int sw, input int imp);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_sweep_cnt"}, 64'(sweep_cnt), 64'(sw));
        check({name, "_improve_cnt"}, 64'(improve_cnt), 64'(imp));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_ev_count"}, 64'(ev_count), 64'(exp_evs));
    endtask

    initial begin
        int n;
        // Reset state: every output must be low.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, ev_valid, rev_valid, ev_i, ev_j, rev_lo, rev_hi,
                                     sweep_cnt, improve_cnt}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: gain is zero everywhere, so one sweep runs and finishes with no reversal.
        prep(1);
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_ev_valid", 64'(ev_valid), 64'd1);
        check("start_pair", 64'({ev_i, ev_j}), 64'({6'd0, 6'd2}));
        wait_done("t1", 8000);
        end_checks("t1", 1, 0);
        check("t1_requests", 64'(ev_count), 64'd1952);
        check("t1_last_pair", 64'(last_i * 100 + last_j), 64'd6163);

        // Test 2 and 3: +5 on (3,10) in the first sweep only, else -1. The first ev request and the rev request both stall.
        prep(2);
        ev_hold = 5; rev_hold = 3;
`ifdef TSP_SCHED_RESTART_EN
        push_sweep(3, 10, 1'b0, 1'b1);
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        wait_done("t2", 20000);
        end_checks("t2", 1, 1);
`else
        push_sweep(3, 10, 1'b0, 1'b0);
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        wait_done("t2", 20000);
        end_checks("t2", 2, 1);
`endif
        check("t2_stalls_consumed", 64'(ev_hold + rev_hold), 64'd0);

        // Test 4: -1020 on (5,20) must not reverse; +1 on (7,30) in the first sweep must.
        prep(4);
`ifdef TSP_SCHED_RESTART_EN
        push_sweep(7, 30, 1'b0, 1'b1);
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        wait_done("t4", 20000);
        end_checks("t4", 1, 1);
`else
        push_sweep(7, 30, 1'b0, 1'b0);
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        wait_done("t4", 20000);
        end_checks("t4", 2, 1);

        // Test 5: gain is always +1, so the sweep cap of 2 ends the run. A start while busy must be ignored.
        prep(5);
        push_sweep(-1, -1, 1'b1, 1'b0);
        push_sweep(-1, -1, 1'b1, 1'b0);
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        check("t5_busy_after_2nd_start", 64'(busy), 64'd1);
        wait_done("t5", 40000);
        end_checks("t5", 2, 3904);
`endif

        // Test 6: assert reset while the DUT waits for rev_done.
        prep(5);
        hold_rev_done = 1'b1;
        push_sweep(0, 2, 1'b0, 1'b1);
        pulse_start();
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("t6_reached_wait_rev", 64'({busy, ev_valid, rev_valid, 6'(exp_q.size())}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", 64'({busy, done, ev_valid, rev_valid, ev_i, ev_j, rev_lo, rev_hi,
                                        sweep_cnt, improve_cnt}), 64'd0);
        hold_rev_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prep(1);
        ev_hold = 1000;
        push_sweep(-1, -1, 1'b0, 1'b0);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        check("t6_restart_pair", 64'({ev_valid, ev_i, ev_j}), 64'({1'b1, 6'd0, 6'd2}));
        check("t6_restart_counters", 64'({sweep_cnt, improve_cnt}), 64'd0);
        check("t6_restart_busy_done", 64'({busy, done}), 64'({1'b1, 1'b0}));
        rst_n = 1'b0;
        ev_hold = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
